// File: rtl/pcie_crdt_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcie_crdt_ctrl: AVST PCIe TX credit init handshake, credit pool and         |
// | round-robin TLP arbiter. Optional macro: PCIE_CRDT_INFINITE_EN.             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pcie_crdt_ctrl #(
  parameter int REQ_NUM    = 4,
  parameter int HDR_CNT_W  = 12,
  parameter int DATA_CNT_W = 16,
  parameter int INIT_QUIET = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  output logic                    CRDT_INIT_DONE,
  input  logic [5:0]              CRDT_UPDATE,
  input  logic [1:0]              CRDT_CNT_PH,
  input  logic [1:0]              CRDT_CNT_NPH,
  input  logic [1:0]              CRDT_CNT_CPLH,
  input  logic [3:0]              CRDT_CNT_PD,
  input  logic [3:0]              CRDT_CNT_NPD,
  input  logic [3:0]              CRDT_CNT_CPLD,
  input  logic [REQ_NUM-1:0]      REQ_VLD,
  input  logic [REQ_NUM*2-1:0]    REQ_TYPE,
  input  logic [REQ_NUM*11-1:0]   REQ_DW,
  output logic [REQ_NUM-1:0]      REQ_GNT,
  output logic                    CRDT_READY,
  output logic                    CRDT_ERR
);

  localparam int c_PW  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int c_QW  = $clog2(INIT_QUIET + 1);
  localparam int c_HSW = HDR_CNT_W + 1;
  localparam int c_DSW = DATA_CNT_W + 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_INIT = 2'd1;
  localparam logic [1:0] c_ST_RUN  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [c_QW-1:0]       r_quiet;
  logic [c_PW-1:0]       r_ptr;
  logic                  r_err;
  logic [HDR_CNT_W-1:0]  r_hdr [3];
  logic [DATA_CNT_W-1:0] r_dat [3];
  logic [5:0]            w_inf;

  logic                  w_run;
  logic                  w_upd_en;
  logic                  w_found;
  logic [c_PW-1:0]       w_cand;
  logic [c_PW-1:0]       w_ptr_nxt;
  logic [1:0]            w_type;
  logic [10:0]           w_dw;
  logic [DATA_CNT_W-1:0] w_dneed;
  logic                  w_hok;
  logic                  w_dok;
  logic                  w_gnt;
  logic                  w_rsv;
  logic [2:0]            w_take;
  logic [5:0]            w_ovf;
  logic [1:0]            w_hcnt [3];
  logic [3:0]            w_dcnt [3];
  logic [c_HSW-1:0]      w_hsum [3];
  logic [c_DSW-1:0]      w_dsum [3];
  logic [HDR_CNT_W-1:0]  w_hsat [3];
  logic [DATA_CNT_W-1:0] w_dsat [3];
  logic [HDR_CNT_W-1:0]  w_hnxt [3];
  logic [DATA_CNT_W-1:0] w_dnxt [3];

  assign w_hcnt[0] = CRDT_CNT_PH;
  assign w_hcnt[1] = CRDT_CNT_NPH;
  assign w_hcnt[2] = CRDT_CNT_CPLH;
  assign w_dcnt[0] = CRDT_CNT_PD;
  assign w_dcnt[1] = CRDT_CNT_NPD;
  assign w_dcnt[2] = CRDT_CNT_CPLD;

  // FSM: state register / next state / outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= c_ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: w_state_nxt = c_ST_INIT;
      c_ST_INIT: if ((CRDT_UPDATE == 6'd0) && (r_quiet == c_QW'(INIT_QUIET - 1)))
                   w_state_nxt = c_ST_RUN;
      c_ST_RUN:  w_state_nxt = c_ST_RUN;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    CRDT_INIT_DONE = (r_state != c_ST_IDLE);
    w_run          = (r_state == c_ST_RUN);
    w_upd_en       = (r_state != c_ST_IDLE);
  end

  assign CRDT_READY = w_run;
  assign CRDT_ERR   = r_err;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_quiet <= '0;
    else if ((r_state == c_ST_INIT) && (CRDT_UPDATE == 6'd0))
      r_quiet <= r_quiet + c_QW'(1);
    else
      r_quiet <= '0;
  end

`ifdef PCIE_CRDT_INFINITE_EN
  logic [5:0] r_inf;
  // Types still empty when INIT ends are never metered afterwards.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_inf <= '0;
    else if ((r_state == c_ST_INIT) && (w_state_nxt == c_ST_RUN))
      r_inf <= {r_dat[2] == '0, r_dat[1] == '0, r_dat[0] == '0,
                r_hdr[2] == '0, r_hdr[1] == '0, r_hdr[0] == '0};
  end
  assign w_inf = r_inf;
`else
  assign w_inf = 6'd0;
`endif

  // Lowest valid index at/after the pointer overrides the wrapped group.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (REQ_VLD[i] && (i < int'(r_ptr))) begin
        w_found = 1'b1;
        w_cand  = c_PW'(i);
      end
    end
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (REQ_VLD[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_cand  = c_PW'(i);
      end
    end
  end

  always_comb begin
    w_type = 2'd0;
    w_dw   = 11'd0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (c_PW'(i) == w_cand) begin
        w_type = REQ_TYPE[2*i +: 2];
        w_dw   = REQ_DW[11*i +: 11];
      end
    end
  end

  assign w_dneed = DATA_CNT_W'(({1'b0, w_dw} + 12'd3) >> 2);

  always_comb begin
    w_hok = 1'b0;
    w_dok = 1'b0;
    case (w_type)
      2'd0: begin
        w_hok = w_inf[0] | (r_hdr[0] != '0);
        w_dok = w_inf[3] | (r_dat[0] >= w_dneed);
      end
      2'd1: begin
        w_hok = w_inf[1] | (r_hdr[1] != '0);
        w_dok = w_inf[4] | (r_dat[1] >= w_dneed);
      end
      2'd2: begin
        w_hok = w_inf[2] | (r_hdr[2] != '0);
        w_dok = w_inf[5] | (r_dat[2] >= w_dneed);
      end
      default: begin
        w_hok = 1'b0;
        w_dok = 1'b0;
      end
    endcase
  end

  assign w_gnt     = w_run & w_found & (w_type != 2'd3) & w_hok & w_dok;
  assign w_rsv     = w_run & w_found & (w_type == 2'd3);
  assign w_ptr_nxt = (w_cand == c_PW'(REQ_NUM - 1)) ? '0 : w_cand + c_PW'(1);

  always_comb begin
    REQ_GNT = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (w_gnt && (c_PW'(i) == w_cand)) REQ_GNT[i] = 1'b1;
  end

  // Saturating add of the return, then deduct the grant taken this edge.
  always_comb begin
    w_ovf  = '0;
    w_take = '0;
    for (int t = 0; t < 3; t++) begin
      w_take[t] = w_gnt && (w_type == 2'(t));
      w_hsum[t] = {1'b0, r_hdr[t]} + ((w_upd_en && CRDT_UPDATE[t])   ? c_HSW'(w_hcnt[t]) : '0);
      w_dsum[t] = {1'b0, r_dat[t]} + ((w_upd_en && CRDT_UPDATE[t+3]) ? c_DSW'(w_dcnt[t]) : '0);
      w_hsat[t] = w_hsum[t][HDR_CNT_W]  ? '1 : w_hsum[t][HDR_CNT_W-1:0];
      w_dsat[t] = w_dsum[t][DATA_CNT_W] ? '1 : w_dsum[t][DATA_CNT_W-1:0];
      if (w_inf[t]) begin
        w_hnxt[t] = r_hdr[t];
      end else begin
        w_hnxt[t] = w_hsat[t] - HDR_CNT_W'(w_take[t]);
        w_ovf[t]  = w_hsum[t][HDR_CNT_W];
      end
      if (w_inf[t+3]) begin
        w_dnxt[t] = r_dat[t];
      end else begin
        w_dnxt[t]  = w_dsat[t] - (w_take[t] ? w_dneed : '0);
        w_ovf[t+3] = w_dsum[t][DATA_CNT_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ptr <= '0;
      r_err <= 1'b0;
      for (int t = 0; t < 3; t++) begin
        r_hdr[t] <= '0;
        r_dat[t] <= '0;
      end
    end else begin
      if (w_gnt || w_rsv) r_ptr <= w_ptr_nxt;
      if ((w_ovf != 6'd0) || w_rsv) r_err <= 1'b1;
      for (int t = 0; t < 3; t++) begin
        r_hdr[t] <= w_hnxt[t];
        r_dat[t] <= w_dnxt[t];
      end
    end
  end

endmodule
`default_nettype wire
